mc_cpu: RTL and testbench

Parametrised multi-cycle successor to the single-cycle core. It executes an RV32I subset through a state machine over one shared instruction/data memory port with a ready handshake, so it tolerates wait-state memory. It adds load/store, BEQ, and an illegal-instruction trap. It sits at the top of the CPU hierarchy: it owns the register file, ALU and PC internally, and exposes only the memory port and the debug/status outputs.

---
 rtl/mc_cpu.sv | 158 +++++++++++++++
 tb/tb_mc_cpu.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_cpu.sv
// mc_cpu: multi-cycle RV32I-subset core (ADD/SUB/ADDI/LW/SW/BEQ/BNE) sharing one
// memory port for fetch and data; a transfer completes on an edge where mem_req and mem_ready are high.
module mc_cpu #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic [WIDTH-1:0] a0_output,
  output logic [WIDTH-1:0] prog_addr,
  output logic             retire,
  output logic             trap
);

  typedef enum logic [2:0] {
    START, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] pc, oldpc, a, b, imm, aluout, mdr;
  logic [31:0]      ir;
  logic [WIDTH-1:0] rf [0:31];

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;
  logic       is_add, is_sub, is_addi, is_lw, is_sw, is_beq, is_bne, is_branch, legal;
  logic [WIDTH-1:0] imm_i, imm_s, imm_b, imm_sel;
  logic       branch_taken;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  assign is_add    = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
  assign is_sub    = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
  assign is_addi   = (opcode == 7'b0010011) && (funct3 == 3'b000);
  assign is_lw     = (opcode == 7'b0000011) && (funct3 == 3'b010);
  assign is_sw     = (opcode == 7'b0100011) && (funct3 == 3'b010);
  assign is_beq    = (opcode == 7'b1100011) && (funct3 == 3'b000);
  assign is_bne    = (opcode == 7'b1100011) && (funct3 == 3'b001);
  assign is_branch = is_beq || is_bne;
  assign legal     = is_add || is_sub || is_addi || is_lw || is_sw || is_branch;

  assign imm_i   = {{(WIDTH-12){ir[31]}}, ir[31:20]};
  assign imm_s   = {{(WIDTH-12){ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b   = {{(WIDTH-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_sel = is_sw ? imm_s : (is_branch ? imm_b : imm_i);

  assign branch_taken = is_beq ? (a == b) : (is_bne && (a != b));

  assign a0_output = rf[10];
  assign prog_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= START;
    else     state <= state_next;
  end

  // Port outputs depend only on state and latched registers, never on mem_ready
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    retire     = 1'b0;
    case (state)
      START: state_next = FETCH;
      FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_ready) state_next = DECODE;
      end
      DECODE: state_next = legal ? EXECUTE : HALT;
      EXECUTE: begin
        if (is_branch) begin
          retire     = 1'b1;
          state_next = FETCH;
        end else if (is_lw || is_sw) begin
          state_next = MEMORY;
        end else begin
          state_next = WRITEBACK;
        end
      end
      MEMORY: begin
        mem_req   = 1'b1;
        mem_we    = is_sw;
        mem_addr  = aluout;
        mem_wdata = b;
        if (mem_ready) begin
          retire     = is_sw;
          state_next = is_sw ? FETCH : WRITEBACK;
        end
      end
      WRITEBACK: begin
        retire     = 1'b1;
        state_next = FETCH;
      end
      HALT: state_next = HALT;
      default: state_next = START;
    endcase
  end

  // rf[0] is only ever written by reset, so it always reads as zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      oldpc  <= '0;
      ir     <= '0;
      a      <= '0;
      b      <= '0;
      imm    <= '0;
      aluout <= '0;
      mdr    <= '0;
      trap   <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ready) begin
            ir    <= mem_rdata[31:0];
            oldpc <= pc;
            pc    <= pc + WIDTH'(4);
          end
        end
        DECODE: begin
          a   <= rf[rs1];
          b   <= rf[rs2];
          imm <= imm_sel;
          if (!legal) trap <= 1'b1;
        end
        EXECUTE: begin
          aluout <= is_add ? (a + b) : (is_sub ? (a - b) : (a + imm));
          if (branch_taken) pc <= oldpc + imm;
        end
        MEMORY: begin
          if (mem_ready && is_lw) mdr <= mem_rdata;
        end
        WRITEBACK: begin
          if (rd != 5'd0) rf[rd] <= is_lw ? mdr : aluout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_cpu.sv
// Self-checking bench for mc_cpu: directed programs plus random programs run against an
// instruction-level reference interpreter, with a wait-state memory model on the shared port.
module tb_mc_cpu;

  localparam int          W   = 32;
  localparam logic [31:0] RPC = 32'h0;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         mem_req, mem_we, retire, trap;
  logic [W-1:0] mem_addr, mem_wdata, a0_output, prog_addr;
  logic [W-1:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [31:0] tb_mem [0:1023];
  logic [31:0] m_mem  [0:1023];
  logic [31:0] m_r    [0:31];
  logic [31:0] m_pc;
  bit          m_halt;
  logic [31:0] prog [$];

  int          wait_mode = 0;
  int          total_waits = 0;
  bit          busy = 0;
  int          wleft = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic        cap_we;

  mc_cpu #(.WIDTH(W), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .a0_output(a0_output), .prog_addr(prog_addr), .retire(retire), .trap(trap)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
    logic [11:0] i = 12'(imm);
    return {i, 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
    logic [11:0] s = 12'(imm);
    return {s[11:5], 5'(rs2), 5'(rs1), 3'd2, s[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    logic [12:0] x = 13'(imm);
    return {x[12], x[10:5], 5'(rs2), 5'(rs1), 3'(f3), x[4:1], x[11], 7'h63};
  endfunction

  // One clock of the memory model: decide ready/rdata after the edge, sample DUT at negedge
  task automatic step_cycle();
    logic [9:0] idx;
    @(posedge clk);
    #1;
    if (rst || !mem_req) begin
      mem_ready = 1'b0;
      busy = 0;
      if (!mem_req) checkOutput("port_idle_zero", {mem_we, mem_wdata}, '0);
    end else begin
      if (!busy) begin
        busy = 1;
        wleft = (wait_mode < 0) ? int'($urandom_range(0, 2)) : wait_mode;
        cap_addr = mem_addr; cap_we = mem_we; cap_wdata = mem_wdata;
      end else begin
        checkOutput("req_stable", {mem_we, mem_addr, mem_wdata}, {cap_we, cap_addr, cap_wdata});
      end
      if (wleft == 0) begin
        idx = mem_addr[11:2];
        mem_ready = 1'b1;
        mem_rdata = tb_mem[idx];
        if (mem_we) tb_mem[idx] = mem_wdata;
        busy = 0;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        wleft--;
        total_waits++;
      end
    end
    @(negedge clk);
  endtask

  // Async reset pulse with immediate output checks, then model reinit
  task automatic applyStimulus();
    rst = 1'b1;
    #1;
    checkOutput("rst_mem_req", mem_req, 1'b0);
    checkOutput("rst_retire", retire, 1'b0);
    checkOutput("rst_trap", trap, 1'b0);
    checkOutput("rst_a0", a0_output, '0);
    checkOutput("rst_pc", prog_addr, RPC);
    step_cycle();
    step_cycle();
    rst = 1'b0;
    m_pc = RPC;
    m_halt = 0;
    for (int i = 0; i < 32; i++) m_r[i] = '0;
  endtask

  task automatic poke(input logic [31:0] addr, input logic [31:0] val);
    tb_mem[addr[11:2]] = val;
    m_mem[addr[11:2]] = val;
  endtask

  task automatic load_prog();
    logic [31:0] v;
    for (int i = 0; i < 1024; i++) begin
      v = (i >= 128 && i < 256) ? $urandom : 32'h0;
      tb_mem[i] = v;
      m_mem[i] = v;
    end
    foreach (prog[i]) poke(RPC + 32'(4 * i), prog[i]);
  endtask

  // Instruction-level reference: applies one instruction to the model state
  task automatic model_exec(input logic [31:0] ins, output int base, output bit ill,
                            output bit st, output int st_idx);
    logic [6:0]  op = ins[6:0];
    logic [2:0]  f3 = ins[14:12];
    logic [6:0]  f7 = ins[31:25];
    int          rd = int'(ins[11:7]);
    logic [31:0] x = m_r[ins[19:15]];
    logic [31:0] y = m_r[ins[24:20]];
    int          immi = int'($signed(ins[31:20]));
    int          imms = int'($signed({ins[31:25], ins[11:7]}));
    int          immb = int'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    logic [31:0] res = '0;
    logic [31:0] ea;
    logic [31:0] next = m_pc + 32'd4;
    bit          wr = 0;
    base = 0; ill = 0; st = 0; st_idx = 0;
    if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h00) begin
      res = x + y; wr = 1; base = 4;
    end else if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h20) begin
      res = x - y; wr = 1; base = 4;
    end else if (op == 7'h13 && f3 == 3'd0) begin
      res = x + 32'(immi); wr = 1; base = 4;
    end else if (op == 7'h03 && f3 == 3'd2) begin
      ea = x + 32'(immi);
      res = m_mem[ea[11:2]]; wr = 1; base = 5;
    end else if (op == 7'h23 && f3 == 3'd2) begin
      ea = x + 32'(imms);
      st_idx = int'(ea[11:2]);
      m_mem[st_idx] = y; st = 1; base = 4;
    end else if (op == 7'h63 && (f3 == 3'd0 || f3 == 3'd1)) begin
      if ((x == y) == (f3 == 3'd0)) next = m_pc + 32'(immb);
      base = 3;
    end else begin
      ill = 1;
    end
    if (!ill) begin
      if (wr && rd != 0) m_r[rd] = res;
      m_pc = next;
    end
  endtask

  task automatic exec_one();
    logic [31:0] ins, pc0;
    int base, cnt, w0, st_idx;
    bit ill, st;
    w0 = total_waits;
    step_cycle();
    checkOutput("fetch_pc", prog_addr, m_pc);
    checkOutput("fetch_req", {mem_req, mem_we, mem_addr}, {2'b10, m_pc});
    checkOutput("a0_value", a0_output, m_r[10]);
    checkOutput("trap_clear", trap, 1'b0);
    pc0 = m_pc;
    ins = m_mem[m_pc[11:2]];
    model_exec(ins, base, ill, st, st_idx);
    if (ill) begin
      repeat (6) begin
        step_cycle();
        checkOutput("halt_no_retire", retire, 1'b0);
      end
      checkOutput("halt_state", {trap, mem_req}, 2'b10);
      checkOutput("halt_pc", prog_addr, pc0 + 32'd4);
      m_halt = 1;
    end else begin
      cnt = 1;
      while (!retire && cnt < 40) begin
        step_cycle();
        cnt++;
      end
      checkOutput("retired", retire, 1'b1);
      checkOutput("latency", cnt, base + total_waits - w0);
      if (st) checkOutput("store_data", tb_mem[st_idx], m_mem[st_idx]);
    end
  endtask

  task automatic run_prog();
    int n = 0;
    int bad = 0;
    while (!m_halt && n < 200) begin
      exec_one();
      n++;
    end
    for (int i = 128; i < 256; i++) if (tb_mem[i] !== m_mem[i]) bad++;
    checkOutput("data_region", bad, 0);
  endtask

  function automatic int pick_rd();
    return ($urandom_range(0, 1) == 1) ? 10 : int'($urandom_range(0, 15));
  endfunction

  task automatic gen_random(input int n);
    int addr;
    prog.delete();
    for (int i = 0; i < n; i++) begin
      addr = 32'h200 + 4 * int'($urandom_range(0, 127));
      case ($urandom_range(0, 9))
        2: prog.push_back(enc_r(0, $urandom_range(0, 15), $urandom_range(0, 15), pick_rd()));
        3: prog.push_back(enc_r(32, $urandom_range(0, 15), $urandom_range(0, 15), pick_rd()));
        4, 5: prog.push_back(enc_s(addr, $urandom_range(0, 15), 0));
        6: prog.push_back(enc_i(addr, 0, 2, pick_rd(), 7'h03));
        7: prog.push_back(enc_b(8, $urandom_range(0, 15), $urandom_range(0, 15), 0));
        8: prog.push_back(enc_b(8, $urandom_range(0, 15), $urandom_range(0, 15), 1));
        default: prog.push_back(enc_i($urandom_range(0, 4095), $urandom_range(0, 15), 0, pick_rd(), 7'h13));
      endcase
    end
    case ($urandom_range(0, 4))
      0: prog.push_back(32'hFFFF_FFFF);
      1: prog.push_back(enc_r(1, 1, 2, 10));
      2: prog.push_back(enc_i(1, 0, 1, 10, 7'h13));
      3: prog.push_back(enc_i(0, 0, 0, 10, 7'h03));
      default: prog.push_back(enc_b(8, 1, 2, 4));
    endcase
  endtask

  initial begin
    #2;

    $display("[TB] ALU sequence, zero-wait");
    prog = '{enc_i(5, 0, 0, 10, 7'h13), enc_r(0, 10, 10, 10), 32'hFFFF_FFFF};
    load_prog();
    wait_mode = 0;
    applyStimulus();
    run_prog();
    checkOutput("alu_a0", a0_output, 32'd10);

    $display("[TB] load/store with two wait states");
    prog = '{enc_i(32'h104, 0, 2, 5, 7'h03), enc_s(32'h100, 5, 0),
             enc_i(32'h100, 0, 2, 10, 7'h03), 32'hFFFF_FFFF};
    load_prog();
    poke(32'h104, 32'h0000_DEAD);
    wait_mode = 2;
    applyStimulus();
    run_prog();
    checkOutput("ls_a0", a0_output, 32'h0000_DEAD);
    checkOutput("ls_mem", tb_mem[64], 32'h0000_DEAD);

    $display("[TB] BNE countdown loop");
    prog = '{enc_i(3, 0, 0, 10, 7'h13), enc_i(-1, 10, 0, 10, 7'h13),
             enc_b(-4, 0, 10, 1), 32'hFFFF_FFFF};
    load_prog();
    wait_mode = -1;
    applyStimulus();
    run_prog();
    checkOutput("loop_a0", a0_output, 32'd0);
    checkOutput("loop_pc", prog_addr, 32'd16);

    $display("[TB] x0 discard and wraparound");
    prog = '{enc_i(7, 0, 0, 0, 7'h13), enc_i(5, 0, 0, 10, 7'h13), enc_r(0, 0, 0, 10),
             enc_i(-1, 0, 0, 11, 7'h13), enc_i(3, 0, 0, 10, 7'h13),
             enc_i(1, 11, 0, 10, 7'h13), 32'hFFFF_FFFF};
    load_prog();
    wait_mode = 0;
    applyStimulus();
    run_prog();
    checkOutput("wrap_a0", a0_output, 32'd0);

    $display("[TB] illegal first instruction");
    prog = '{32'hFFFF_FFFF};
    load_prog();
    wait_mode = -1;
    applyStimulus();
    run_prog();
    repeat (3) step_cycle();
    checkOutput("illegal_hold", {trap, mem_req, retire}, 3'b100);
    checkOutput("illegal_pc", prog_addr, RPC + 32'd4);
    applyStimulus();
    checkOutput("illegal_rst_trap", trap, 1'b0);

    $display("[TB] reset during stalled fetch");
    prog = '{enc_i(9, 0, 0, 10, 7'h13), enc_i(1, 10, 0, 10, 7'h13)};
    load_prog();
    wait_mode = 0;
    applyStimulus();
    exec_one();
    wait_mode = 10;
    step_cycle();
    step_cycle();
    checkOutput("stall_req", {mem_req, mem_ready}, 2'b10);
    checkOutput("stall_a0", a0_output, 32'd9);
    checkOutput("stall_pc", prog_addr, RPC + 32'd4);
    applyStimulus();
    wait_mode = 0;
    run_prog();
    checkOutput("refetch_a0", a0_output, 32'd10);

    $display("[TB] random programs");
    wait_mode = -1;
    for (int t = 0; t < 8; t++) begin
      gen_random(int'($urandom_range(10, 40)));
      load_prog();
      applyStimulus();
      run_prog();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
